decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 81 ++++++++
 rtl/decode_logic.sv | 163 ++++++++++++++++
 rtl/decode_stage.sv | 143 ++++++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: ALU codes, opcodes, memory sizes,
// the decoded control bundle and the stage FSM states.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_ADDI    = 4'b0001,
    ALU_LOAD    = 4'b0010,
    ALU_STORE   = 4'b0011,
    ALU_LUI     = 4'b0100,
    ALU_JUMP    = 4'b0101,
    ALU_OR      = 4'b0110,
    ALU_AND     = 4'b0111,
    ALU_BRANCH  = 4'b1000,
    ALU_SUB     = 4'b1001,
    ALU_XOR     = 4'b1010,
    ALU_SLL     = 4'b1011,
    ALU_SRL     = 4'b1100,
    ALU_SRA     = 4'b1101,
    ALU_SLT     = 4'b1110,
    ALU_INVALID = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } stage_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Operand-B select seen by execute
  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_UIMM = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;

  // Width-independent part of the decoded bundle; imm/pc/target live
  // alongside it in the stage because their width follows XLEN.
  typedef struct packed {
    alu_op_e     alu_op;
    logic [1:0]  alu_src;
    logic        we;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } decode_ctrl_t;

  localparam decode_ctrl_t CTRL_RESET = '{
    alu_op: ALU_INVALID, alu_src: SRC_REG, we: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, branch: 1'b0, jump: 1'b0, illegal: 1'b0,
    mem_size: MEM_BYTE, mem_unsigned: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
  };

  // Load/store width encodings accepted in funct3
  function automatic logic mem_funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational instruction decoder: raw instruction + pc in,
// control bundle, sign-extended immediate and pc+imm out.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decode_ctrl_t    ctrl,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] branch_target
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm32;
  logic               bad;
  // On RV32 the shift amount is 5 bits, so instr[25] must be clear
  logic               shamt_hi_bad;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign shamt_hi_bad = (XLEN == 32) && instr[25];

  // Immediate assembly per instruction format, sign taken from bit 31
  always_comb begin
    case (opcode)
      OP_STORE:         imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {instr[31:12], 12'b0};
      OP_JAL:           imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
      default:          imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate up to XLEN
  assign imm           = XLEN'(imm32);
  assign branch_target = pc + imm;

  // Control decode; illegal encodings collapse to a neutral bundle at the end
  always_comb begin
    ctrl = '{
      alu_op: ALU_ADD, alu_src: SRC_REG, we: 1'b0, mem_read: 1'b0,
      mem_write: 1'b0, branch: 1'b0, jump: 1'b0, illegal: 1'b0,
      mem_size: MEM_BYTE, mem_unsigned: 1'b0,
      rs1: instr[19:15], rs2: instr[24:20], rd: instr[11:7]
    };
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.we = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  ctrl.alu_op = ALU_ADD;
            3'b001:  ctrl.alu_op = ALU_SLL;
            3'b010:  ctrl.alu_op = ALU_SLT;
            3'b100:  ctrl.alu_op = ALU_XOR;
            3'b101:  ctrl.alu_op = ALU_SRL;
            3'b110:  ctrl.alu_op = ALU_OR;
            3'b111:  ctrl.alu_op = ALU_AND;
            default: bad = 1'b1;  // unsigned compare has no ALU code
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  ctrl.alu_op = ALU_SUB;
            3'b101:  ctrl.alu_op = ALU_SRA;
            default: bad = 1'b1;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.we      = 1'b1;
        ctrl.alu_src = SRC_IMM;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADDI;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op = ALU_SLL;
            bad = (instr[31:26] != 6'b000000) || shamt_hi_bad;
          end
          3'b101: begin
            ctrl.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
            bad = ((instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000))
                  || shamt_hi_bad;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.alu_op       = ALU_LOAD;
        ctrl.alu_src      = SRC_IMM;
        ctrl.we           = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_size     = mem_size_e'(funct3[1:0]);
        ctrl.mem_unsigned = funct3[2];
        bad               = !mem_funct3_ok(funct3);
      end
      OP_STORE: begin
        ctrl.alu_op       = ALU_STORE;
        ctrl.alu_src      = SRC_IMM;
        ctrl.mem_write    = 1'b1;
        ctrl.mem_size     = mem_size_e'(funct3[1:0]);
        ctrl.mem_unsigned = funct3[2];
        bad               = !mem_funct3_ok(funct3);
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALU_BRANCH;
        ctrl.branch = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op  = ALU_LUI;
        ctrl.alu_src = SRC_UIMM;
        ctrl.we      = 1'b1;
      end
      OP_AUIPC: begin
        // pc + upper immediate; execute routes pc onto operand A
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = SRC_UIMM;
        ctrl.we      = 1'b1;
      end
      OP_JAL: begin
        ctrl.alu_op  = ALU_JUMP;
        ctrl.alu_src = SRC_IMM;
        ctrl.we      = 1'b1;
        ctrl.jump    = 1'b1;
      end
      OP_JALR: begin
        ctrl.alu_op  = ALU_JUMP;
        ctrl.alu_src = SRC_IMM;
        ctrl.we      = 1'b1;
        ctrl.jump    = 1'b1;
        bad          = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      ctrl.alu_op       = ALU_INVALID;
      ctrl.alu_src      = SRC_REG;
      ctrl.we           = 1'b0;
      ctrl.mem_read     = 1'b0;
      ctrl.mem_write    = 1'b0;
      ctrl.branch       = 1'b0;
      ctrl.jump         = 1'b0;
      ctrl.mem_size     = MEM_BYTE;
      ctrl.mem_unsigned = 1'b0;
      ctrl.illegal      = 1'b1;
    end
    // x0 is hard-wired, so never request a write to it
    if (ctrl.rd == 5'd0) ctrl.we = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-cycle decode with ready/valid handshakes on
// both sides. SKID_EN=1 adds a skid entry so in_ready is a pure flop.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_alu_src,
  output logic            out_we,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_branch_target,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd
);

  typedef struct packed {
    decode_ctrl_t    ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{ctrl: CTRL_RESET, imm: '0, pc: '0, tgt: '0};

  decode_ctrl_t    dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_tgt;
  entry_t          dec;

  stage_state_e    state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept, drain;

  decode_logic #(.XLEN(XLEN)) u_decode (
    .instr         (in_instr),
    .pc            (in_pc),
    .ctrl          (dec_ctrl),
    .imm           (dec_imm),
    .branch_target (dec_tgt)
  );

  assign dec = '{ctrl: dec_ctrl, imm: dec_imm, pc: in_pc, tgt: dec_tgt};

  // Without the skid entry, ready must look through to out_ready; in_ready_q
  // then only serves to hold ready low until the first edge after reset.
  assign in_ready  = (SKID_EN != 0) ? in_ready_q
                                    : (in_ready_q && (out_ready || (state_q == ST_EMPTY)));
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Next-state and entry movement; flush wins over everything
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = dec;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_SKID;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            out_d   = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (SKID_EN != 0) ? (state_d != ST_SKID) : 1'b1;
  end

  // State, ready flop and both entries; reset drops everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign out_alu_op        = out_q.ctrl.alu_op;
  assign out_alu_src       = out_q.ctrl.alu_src;
  assign out_we            = out_q.ctrl.we;
  assign out_mem_read      = out_q.ctrl.mem_read;
  assign out_mem_write     = out_q.ctrl.mem_write;
  assign out_branch        = out_q.ctrl.branch;
  assign out_jump          = out_q.ctrl.jump;
  assign out_illegal       = out_q.ctrl.illegal;
  assign out_mem_size      = out_q.ctrl.mem_size;
  assign out_mem_unsigned  = out_q.ctrl.mem_unsigned;
  assign out_rs1           = out_q.ctrl.rs1;
  assign out_rs2           = out_q.ctrl.rs2;
  assign out_rd            = out_q.ctrl.rd;
  assign out_imm           = out_q.imm;
  assign out_pc            = out_q.pc;
  assign out_branch_target = out_q.tgt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, SKID_EN=1).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_alu_src;
  logic        out_we, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;
  logic [1:0]  out_mem_size;
  logic        out_mem_unsigned;
  logic [31:0] out_imm, out_pc, out_branch_target;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_LW    = 32'hFFC12283;
  localparam logic [31:0] I_LHU   = 32'h00015083;
  localparam logic [31:0] I_LBAD  = 32'h00013083;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3;
  localparam logic [31:0] I_JAL   = 32'h020000EF;
  localparam logic [31:0] I_LUI   = 32'h800000B7;
  localparam logic [31:0] I_OP7F  = 32'h000002FF;
  localparam logic [31:0] I_ADDI0 = 32'h00500013;
  localparam logic [31:0] I_A1    = 32'h00100093;
  localparam logic [31:0] I_A2    = 32'h00200113;
  localparam logic [31:0] I_A3    = 32'h00300193;

  decode_stage #(.XLEN(32), .SKID_EN(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_alu_op        (out_alu_op),
    .out_alu_src       (out_alu_src),
    .out_we            (out_we),
    .out_mem_read      (out_mem_read),
    .out_mem_write     (out_mem_write),
    .out_branch        (out_branch),
    .out_jump          (out_jump),
    .out_illegal       (out_illegal),
    .out_mem_size      (out_mem_size),
    .out_mem_unsigned  (out_mem_unsigned),
    .out_imm           (out_imm),
    .out_pc            (out_pc),
    .out_branch_target (out_branch_target),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_rd            (out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_alu_op", 64'(out_alu_op), 64'hF);
    check("rst_imm", 64'(out_imm), 64'd0);
    check("rst_we", 64'(out_we), 64'd0);
    rst = 1'b1;
    check("rel_in_ready_low", 64'(in_ready), 64'd0);
    step();
    check("rel_in_ready_high", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Streaming decode, one instruction per cycle
    drive(1'b1, I_ADD, 32'h0); step();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_alu", 64'(out_alu_op), 64'h0);
    check("add_we", 64'(out_we), 64'd1);
    check("add_rd", 64'(out_rd), 64'd3);
    check("add_rs1", 64'(out_rs1), 64'd1);
    check("add_rs2", 64'(out_rs2), 64'd2);

    drive(1'b1, I_LW, 32'h40); step();
    check("lw_mem_read", 64'(out_mem_read), 64'd1);
    check("lw_size", 64'(out_mem_size), 64'd2);
    check("lw_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("lw_alu", 64'(out_alu_op), 64'h2);
    check("lw_rd", 64'(out_rd), 64'd5);
    check("lw_tgt", 64'(out_branch_target), 64'h3C);

    drive(1'b1, I_BEQ, 32'h100); step();
    check("beq_branch", 64'(out_branch), 64'd1);
    check("beq_tgt", 64'(out_branch_target), 64'hF8);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFF8);
    check("beq_alu", 64'(out_alu_op), 64'h8);
    check("beq_we", 64'(out_we), 64'd0);
    check("beq_pc", 64'(out_pc), 64'h100);

    drive(1'b1, I_SUB, 32'h0); step();
    check("sub_alu", 64'(out_alu_op), 64'h9);
    check("sub_illegal", 64'(out_illegal), 64'd0);

    drive(1'b1, I_MUL, 32'h0); step();
    check("f7_illegal", 64'(out_illegal), 64'd1);
    check("f7_alu", 64'(out_alu_op), 64'hF);
    check("f7_we", 64'(out_we), 64'd0);

    drive(1'b1, I_OP7F, 32'h0); step();
    check("op7f_valid", 64'(out_valid), 64'd1);
    check("op7f_illegal", 64'(out_illegal), 64'd1);
    check("op7f_alu", 64'(out_alu_op), 64'hF);
    check("op7f_we", 64'(out_we), 64'd0);

    drive(1'b1, I_ADDI0, 32'h0); step();
    check("addi0_illegal", 64'(out_illegal), 64'd0);
    check("addi0_alu", 64'(out_alu_op), 64'h1);
    check("addi0_we", 64'(out_we), 64'd0);
    check("addi0_mem_read", 64'(out_mem_read), 64'd0);
    check("addi0_src", 64'(out_alu_src), 64'd2);

    drive(1'b1, I_LHU, 32'h0); step();
    check("lhu_size", 64'(out_mem_size), 64'd1);
    check("lhu_unsigned", 64'(out_mem_unsigned), 64'd1);
    check("lhu_mem_read", 64'(out_mem_read), 64'd1);

    drive(1'b1, I_SW, 32'h200); step();
    check("sw_mem_write", 64'(out_mem_write), 64'd1);
    check("sw_mem_read", 64'(out_mem_read), 64'd0);
    check("sw_imm", 64'(out_imm), 64'd8);
    check("sw_we", 64'(out_we), 64'd0);
    check("sw_alu", 64'(out_alu_op), 64'h3);
    check("sw_tgt", 64'(out_branch_target), 64'h208);

    drive(1'b1, I_LBAD, 32'h0); step();
    check("lbad_illegal", 64'(out_illegal), 64'd1);
    check("lbad_mem_read", 64'(out_mem_read), 64'd0);

    drive(1'b1, I_JAL, 32'hFFFFFFF0); step();
    check("jal_jump", 64'(out_jump), 64'd1);
    check("jal_tgt_wrap", 64'(out_branch_target), 64'h10);
    check("jal_we", 64'(out_we), 64'd1);
    check("jal_alu", 64'(out_alu_op), 64'h5);

    drive(1'b1, I_LUI, 32'h0); step();
    check("lui_imm", 64'(out_imm), 64'h80000000);
    check("lui_alu", 64'(out_alu_op), 64'h4);
    check("lui_src", 64'(out_alu_src), 64'd1);

    drive(1'b0, 32'h0, 32'h0); step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Backpressure: FULL, then SKID, third instruction held off
    out_ready = 1'b0;
    drive(1'b1, I_A1, 32'h0); step();
    check("sk1_valid", 64'(out_valid), 64'd1);
    check("sk1_rd", 64'(out_rd), 64'd1);
    check("sk1_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, I_A2, 32'h4); step();
    check("sk2_in_ready", 64'(in_ready), 64'd0);
    check("sk2_rd_hold", 64'(out_rd), 64'd1);
    drive(1'b1, I_A3, 32'h8); step();
    check("sk3_in_ready", 64'(in_ready), 64'd0);
    check("sk3_rd_hold", 64'(out_rd), 64'd1);
    check("sk3_imm_hold", 64'(out_imm), 64'd1);
    out_ready = 1'b1; step();
    check("dr1_rd", 64'(out_rd), 64'd2);
    check("dr1_pc", 64'(out_pc), 64'h4);
    check("dr1_in_ready", 64'(in_ready), 64'd1);
    step();
    check("dr2_rd", 64'(out_rd), 64'd3);
    check("dr2_pc", 64'(out_pc), 64'h8);
    drive(1'b0, 32'h0, 32'h0); step();
    check("dr3_empty", 64'(out_valid), 64'd0);

    // Flush while in SKID with a new instruction offered
    out_ready = 1'b0;
    drive(1'b1, I_A1, 32'h0); step();
    drive(1'b1, I_A2, 32'h4); step();
    check("fl_pre_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; drive(1'b1, I_A3, 32'h8); step();
    check("fl_skid_valid", 64'(out_valid), 64'd0);
    check("fl_skid_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1; step();
    check("fl_skid_nothing", 64'(out_valid), 64'd0);

    // Flush from FULL beats a simultaneous accept
    out_ready = 1'b0;
    drive(1'b1, I_A1, 32'h0); step();
    check("fl_full_pre", 64'(out_valid), 64'd1);
    flush = 1'b1; drive(1'b1, I_A2, 32'h4); step();
    check("fl_full_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1; step();
    check("fl_full_nothing", 64'(out_valid), 64'd0);

    // Asynchronous reset with an entry in flight
    out_ready = 1'b0;
    drive(1'b1, I_A1, 32'h0); step();
    rst = 1'b0; #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    check("mrst_alu", 64'(out_alu_op), 64'hF);
    drive(1'b0, 32'h0, 32'h0); step();
    rst = 1'b1; step();
    check("mrst_rel_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1; step();
    check("mrst_nothing", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
